axi_hp_burst_writer: RTL

Upstream master for the 64-bit AXI_HP write port. It takes a command (start address and length in 64-bit words) plus a data stream, and splits the transfer into AXI3 INCR bursts of at most 16 beats that never cross a 4KB boundary. It drives the AW/W channels of the HP write port, collects B responses, and reports completion and errors. It sits between the fabric DMA clients and the HP write port (or its simulation model).

---
 rtl/axi_hp_burst_writer_if.sv | 37 +++
 rtl/axi_hp_burst_writer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/axi_hp_burst_writer_if.sv
// AW/W/B signal bundle of the 64-bit HP write port.
// The master modport is the burst writer; the slave modport is the port or its model.
interface axi_hp_burst_writer_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [5:0]  awid;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awqos;
  logic [63:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [5:0]  wid;
  logic        wlast;
  logic [7:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [5:0]  bid;
  logic [1:0]  bresp;

  modport master (
    output awaddr, awvalid, awid, awlock, awcache, awprot, awlen, awsize, awburst, awqos,
    output wdata, wvalid, wid, wlast, wstrb, bready,
    input  awready, wready, bvalid, bid, bresp
  );

  modport slave (
    input  awaddr, awvalid, awid, awlock, awcache, awprot, awlen, awsize, awburst, awqos,
    input  wdata, wvalid, wid, wlast, wstrb, bready,
    output awready, wready, bvalid, bid, bresp
  );
endinterface

// File: rtl/axi_hp_burst_writer.sv
// Splits a word-count write command into AXI3 INCR bursts (<=16 beats, no 4KB crossing)
// and streams din onto the W channel; tracks outstanding B responses.
module axi_hp_burst_writer #(
  parameter logic [5:0] AXI_ID          = 6'h0,
  parameter logic [3:0] QOS             = 4'h0,
  parameter int         MAX_OUTSTANDING = 4
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic [28:0] cmd_addr,
  input  logic [15:0] cmd_nwords,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [63:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  axi_hp_burst_writer_if.master axi
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_FIN} state_t;

  state_t      state_q;
  logic [28:0] addr_q;
  logic [15:0] remaining_q;
  logic [3:0]  beats_left_q;
  logic [3:0]  outstanding_q;
  logic [3:0]  outstanding_d;
  logic        busy_q;
  logic        done_q;
  logic        error_q;

  logic [4:0]  rem_cap;
  logic [9:0]  to_4k;
  logic [4:0]  burst_len;
  logic [4:0]  burst_len_m1;
  logic        aw_fire;
  logic        w_fire;
  logic        in_data;

  // Words left before the next 4KB boundary (512 words per page).
  assign rem_cap      = (remaining_q > 16'd16) ? 5'd16 : remaining_q[4:0];
  assign to_4k        = 10'd512 - {1'b0, addr_q[8:0]};
  assign burst_len    = ({5'b0, rem_cap} < to_4k) ? rem_cap : to_4k[4:0];
  assign burst_len_m1 = burst_len - 5'd1;

  assign in_data  = (state_q == S_DATA);
  assign aw_fire  = axi.awvalid && axi.awready;
  assign w_fire   = axi.wvalid && axi.wready;

  assign axi.awaddr  = {addr_q, 3'b000};
  assign axi.awvalid = (state_q == S_ADDR) && (outstanding_q < MAX_OUT);
  assign axi.awlen   = burst_len_m1[3:0];
  assign axi.awid    = AXI_ID;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0011;
  assign axi.awprot  = 3'b000;
  assign axi.awsize  = 3'h3;
  assign axi.awburst = 2'b01;
  assign axi.awqos   = QOS;
  assign axi.wdata   = din;
  assign axi.wvalid  = in_data && din_valid;
  assign axi.wlast   = in_data && (beats_left_q == 4'd0);
  assign axi.wid     = AXI_ID;
  assign axi.wstrb   = 8'hff;
  assign axi.bready  = 1'b1;

  assign din_ready = in_data && axi.wready;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

  // Late responses after a reset must not wrap the counter below zero.
  always_comb begin
    outstanding_d = outstanding_q;
    if (aw_fire && !axi.bvalid) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!aw_fire && axi.bvalid && (outstanding_q != 4'd0)) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      beats_left_q  <= '0;
      outstanding_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      done_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // busy_q stays high through the done cycle, so a start there is ignored.
          if (cmd_start && !busy_q) begin
            addr_q      <= cmd_addr;
            remaining_q <= cmd_nwords;
            error_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= (cmd_nwords == 16'd0) ? S_FIN : S_ADDR;
          end else if (done_q) begin
            busy_q <= 1'b0;
          end
        end
        S_ADDR: begin
          if (aw_fire) begin
            addr_q       <= addr_q + {24'b0, burst_len};
            remaining_q  <= remaining_q - {11'b0, burst_len};
            beats_left_q <= burst_len_m1[3:0];
            state_q      <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_fire) begin
            if (beats_left_q != 4'd0) begin
              beats_left_q <= beats_left_q - 4'd1;
            end else begin
              state_q <= (remaining_q != 16'd0) ? S_ADDR : S_RESP;
            end
          end
        end
        S_RESP: begin
          if (outstanding_d == 4'd0) begin
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (axi.bvalid && ((axi.bresp != 2'b00) || (axi.bid != AXI_ID))) begin
        error_q <= 1'b1;
      end
    end
  end

endmodule
